regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Issue-side controller for the 32-entry register file in the pipeline CPU. After reset it sequences a zeroing sweep of the register file. It then tracks in-flight destination registers with a busy bit each, and gates instruction issue from decode on RAW/WAW hazards until the matching writeback retires. It also provides a drain handshake so control logic can wait for all pending writebacks.

## Interface
- NUM_REGS, 32, number of architectural registers; entry 0 is hardwired zero.
- IDX_W, 5, register index width (log2 NUM_REGS).
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  decode presents an instruction.
- issue_rs1_index, issue_rs2_index, issue_rd_index  input  IDX_W  source/destination indices.
- issue_rs1_used, issue_rs2_used, issue_rd_wen  input  1  operand used / instruction writes rd.
- issue_ready  output  1  instruction may issue; issue fires when issue_valid && issue_ready.
- wb_en  input  1  writeback stage retires a register write (same qualifier as the regfile write enable).
- wb_index  input  IDX_W  register written by that writeback.
- kill_en  input  1  squashed in-flight instruction will never write back.
- kill_index  input  IDX_W  its rd.
- drain_req  input  1  level request: stop issue and wait for zero pending writes.
- drain_done  output  1  drain complete.
- rf_init_we  output  1  zeroing write enable to regfile write port during sweep.
- rf_init_index  output  IDX_W  register being zeroed (data is implicitly 0).
- busy_vec  output  NUM_REGS  registered busy bits; bit 0 always 0.
- pending_count  output  IDX_W+1  registered popcount of busy_vec.
- err  output  1  sticky protocol error.

## Operation
- States: INIT, RUN, DRAIN.
- INIT: rf_init_we=1, rf_init_index steps 1,2,…,NUM_REGS-1, one per cycle, then RUN.
  - issue_ready=0.
  - wb_en/kill_en ignored, no err.
- RUN: hazard = issue_valid && any of the following:
  - (rs1_used && busy[rs1])
  - (rs2_used && busy[rs2])
  - (rd_wen && busy[rd])
- Index 0 never hazards and is never set busy.
- issue_ready = !hazard, computed from registered busy_vec only; no same-cycle bypass of wb_en, because the regfile has no internal write-to-read bypass.
- On fire with rd_wen && rd!=0: busy[rd] set at next edge.
- wb_en with wb_index!=0 clears busy[wb_index]; kill_en does the same for kill_index.
- Clear of a non-busy nonzero index sets err. err stays set until rst.
- wb and kill in the same cycle on different indices both clear. If they name the same index: one clear, and err set.
- Set and clear of the same index in one cycle cannot occur, since a WAW stall blocks it. If it is forced, the clear wins.
- RUN→DRAIN when drain_req=1.
  - In DRAIN: issue_ready=0 and clears still apply.
  - drain_done=1 while pending_count==0.
  - DRAIN→RUN when drain_req=0; drain_done drops the same edge.
- pending_count = popcount of next busy_vec, registered alongside it.

## Timing
- Reset values:
  - State INIT, sweep pointer 1.
  - busy_vec=0, pending_count=0, issue_ready=0, drain_done=0, err=0.
  - rf_init_we=0, rf_init_index=0.
- Cycle 1 (first edge after rst falls): rf_init_we=1, index=1.
- Cycle 31: index=31.
- Cycle 32: rf_init_we=0, index=0, state RUN; issue_ready may assert.
- Issue-to-busy latency 1 cycle. A dependent instruction is stalled from the next cycle.
- Writeback clear latency 1 cycle. A stalled consumer fires the cycle after wb_en.
- drain_done asserts 1 cycle after the clear that brings pending_count to 0. It asserts 1 cycle after DRAIN entry if nothing is pending.
- rst asserted mid-sweep or mid-run: immediate return to reset values; the sweep restarts from 1.

## Test plan
- Reset then idle: rf_init_we high exactly 31 cycles with indices 1..31 ascending; issue_ready rises cycle 32; busy_vec=0.
- RAW on x5:
  - Issue rd=5 → busy_vec=0x20, pending_count=1.
  - Next instruction rs1=5 stalls.
  - wb_en with wb_index=5 → stall lifts the following cycle; busy_vec=0.
- Issue rd=0 and rd=5 then rd=5 again: x0 never busy; the second rd=5 stalls (WAW) until wb 5.
- Issue rd=3, rd=7; kill_en on 3 and wb_en on 7 in the same cycle → busy_vec=0, err=0. A later wb_en to index 9 (not busy) → err=1 and stays 1.
- Drain with busy={3,7}:
  - drain_req=1 → issue_ready=0.
  - wb 3, then wb 7 → drain_done=1 one cycle after the second clear.
  - drain_req=0 → RUN, issue resumes.
- rst pulse at sweep index 12 and again with busy_vec=0x88: all outputs return to reset values; the sweep restarts at 1.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Issue-side scoreboard for the 32-entry register file: post-reset zeroing sweep,
// per-register busy tracking with RAW/WAW issue gating, and a drain handshake.
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [IDX_W-1:0]    issue_rs1_index,
    input  logic [IDX_W-1:0]    issue_rs2_index,
    input  logic [IDX_W-1:0]    issue_rd_index,
    input  logic                issue_rs1_used,
    input  logic                issue_rs2_used,
    input  logic                issue_rd_wen,
    output logic                issue_ready,
    input  logic                wb_en,
    input  logic [IDX_W-1:0]    wb_index,
    input  logic                kill_en,
    input  logic [IDX_W-1:0]    kill_index,
    input  logic                drain_req,
    output logic                drain_done,
    output logic                rf_init_we,
    output logic [IDX_W-1:0]    rf_init_index,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [IDX_W:0]      pending_count,
    output logic                err
);
    typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN} state_t;

    state_t              state_q;
    logic [IDX_W:0]      sweep_q;
    logic                rf_init_we_q;
    logic [IDX_W-1:0]    rf_init_index_q;
    logic                drain_done_q;
    logic [NUM_REGS-1:0] busy_q, busy_d, set_mask, clr_mask;
    logic [IDX_W:0]      pending_q, pending_d;
    logic                err_q, err_d;
    logic                hazard, fire, active;
    logic                wb_clr, kill_clr, wb_bad, kill_bad;

    function automatic logic [IDX_W:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Hazard uses only registered busy bits: the regfile cannot forward a same-cycle write.
    assign hazard = issue_valid && ((issue_rs1_used && busy_q[issue_rs1_index]) ||
                                    (issue_rs2_used && busy_q[issue_rs2_index]) ||
                                    (issue_rd_wen   && busy_q[issue_rd_index]));
    assign issue_ready = (state_q == S_RUN) && !hazard;
    assign fire        = issue_valid && issue_ready;
    assign active      = (state_q != S_INIT);
    assign wb_clr      = active && wb_en && (wb_index != '0);
    assign kill_clr    = active && kill_en && (kill_index != '0);
    assign wb_bad      = wb_clr && !busy_q[wb_index];
    assign kill_bad    = kill_clr && (!busy_q[kill_index] || (wb_clr && (wb_index == kill_index)));

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (fire && issue_rd_wen && (issue_rd_index != '0)) begin
            set_mask[issue_rd_index] = 1'b1;
        end
        if (wb_clr) begin
            clr_mask[wb_index] = 1'b1;
        end
        if (kill_clr) begin
            clr_mask[kill_index] = 1'b1;
        end
        // Clear applied after set so a forced set/clear collision leaves the bit clear.
        busy_d    = (busy_q | set_mask) & ~clr_mask;
        pending_d = popcount(busy_d);
        err_d     = err_q | wb_bad | kill_bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_INIT;
            sweep_q         <= (IDX_W+1)'(1);
            rf_init_we_q    <= 1'b0;
            rf_init_index_q <= '0;
            drain_done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (sweep_q == (IDX_W+1)'(NUM_REGS)) begin
                        state_q         <= S_RUN;
                        rf_init_we_q    <= 1'b0;
                        rf_init_index_q <= '0;
                    end else begin
                        rf_init_we_q    <= 1'b1;
                        rf_init_index_q <= sweep_q[IDX_W-1:0];
                        sweep_q         <= sweep_q + (IDX_W+1)'(1);
                    end
                end
                S_RUN: begin
                    drain_done_q <= 1'b0;
                    if (drain_req) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!drain_req) begin
                        state_q      <= S_RUN;
                        drain_done_q <= 1'b0;
                    end else begin
                        drain_done_q <= (pending_q == '0);
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign drain_done    = drain_done_q;
    assign rf_init_we    = rf_init_we_q;
    assign rf_init_index = rf_init_index_q;
    assign busy_vec      = busy_q;
    assign pending_count = pending_q;
    assign err           = err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus randomized traffic, all
// outputs compared every cycle against an array-based reference model.
module tb_regfile_scoreboard;
    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                issue_valid;
    logic [IDX_W-1:0]    issue_rs1_index, issue_rs2_index, issue_rd_index;
    logic                issue_rs1_used, issue_rs2_used, issue_rd_wen;
    logic                issue_ready;
    logic                wb_en;
    logic [IDX_W-1:0]    wb_index;
    logic                kill_en;
    logic [IDX_W-1:0]    kill_index;
    logic                drain_req;
    logic                drain_done;
    logic                rf_init_we;
    logic [IDX_W-1:0]    rf_init_index;
    logic [NUM_REGS-1:0] busy_vec;
    logic [IDX_W:0]      pending_count;
    logic                err;

    regfile_scoreboard #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid),
        .issue_rs1_index(issue_rs1_index), .issue_rs2_index(issue_rs2_index),
        .issue_rd_index(issue_rd_index),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .issue_rd_wen(issue_rd_wen),
        .issue_ready(issue_ready),
        .wb_en(wb_en), .wb_index(wb_index),
        .kill_en(kill_en), .kill_index(kill_index),
        .drain_req(drain_req), .drain_done(drain_done),
        .rf_init_we(rf_init_we), .rf_init_index(rf_init_index),
        .busy_vec(busy_vec), .pending_count(pending_count), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: edges seen since reset, one busy flag per register, drain mode.
    int m_sweep;
    bit m_busy[NUM_REGS];
    bit m_drain, m_done, m_err;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NUM_REGS-1:0] m_busy_vec();
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic int m_pending();
        int n = 0;
        for (int i = 0; i < NUM_REGS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic bit m_ready();
        bit hz;
        hz = issue_valid && ((issue_rs1_used && m_busy[issue_rs1_index]) ||
                             (issue_rs2_used && m_busy[issue_rs2_index]) ||
                             (issue_rd_wen   && m_busy[issue_rd_index]));
        return (m_sweep >= NUM_REGS) && !m_drain && !hz;
    endfunction

    task automatic model_reset();
        m_sweep = 0;
        for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
        m_drain = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge();
        bit nb[NUM_REGS];
        int oldp;
        if (m_sweep < NUM_REGS) begin
            m_sweep++;
            return;
        end
        oldp = m_pending();
        nb = m_busy;
        if (issue_valid && m_ready() && issue_rd_wen && issue_rd_index != 0) nb[issue_rd_index] = 1'b1;
        if (wb_en && wb_index != 0) begin
            if (!m_busy[wb_index]) m_err = 1'b1;
            nb[wb_index] = 1'b0;
        end
        if (kill_en && kill_index != 0) begin
            if (!m_busy[kill_index] || (wb_en && wb_index == kill_index)) m_err = 1'b1;
            nb[kill_index] = 1'b0;
        end
        if (!m_drain) begin
            m_done = 1'b0;
            if (drain_req) m_drain = 1'b1;
        end else if (!drain_req) begin
            m_drain = 1'b0;
            m_done  = 1'b0;
        end else begin
            m_done = (oldp == 0);
        end
        m_busy = nb;
    endtask

    task automatic check_outputs(input string tag);
        bit sweeping;
        sweeping = (m_sweep >= 1) && (m_sweep <= NUM_REGS - 1);
        check_eq({tag, "/busy_vec"}, busy_vec, m_busy_vec());
        check_eq({tag, "/pending"}, pending_count, m_pending());
        check_eq({tag, "/drain_done"}, drain_done, m_done);
        check_eq({tag, "/err"}, err, m_err);
        check_eq({tag, "/init_we"}, rf_init_we, sweeping);
        check_eq({tag, "/init_idx"}, rf_init_index, sweeping ? m_sweep : 0);
        check_eq({tag, "/ready"}, issue_ready, m_ready());
    endtask

    task automatic step(input string tag);
        #1;
        check_eq({tag, "/ready_pre"}, issue_ready, m_ready());
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rs1_index = 0; issue_rs2_index = 0; issue_rd_index = 0;
        issue_rs1_used = 0; issue_rs2_used = 0; issue_rd_wen = 0;
        wb_en = 0; wb_index = 0; kill_en = 0; kill_index = 0;
    endtask

    task automatic set_issue(input logic v, input int rs1, input logic u1, input int rs2,
                             input logic u2, input int rd, input logic wen);
        issue_valid = v;
        issue_rs1_index = IDX_W'(rs1); issue_rs1_used = u1;
        issue_rs2_index = IDX_W'(rs2); issue_rs2_used = u2;
        issue_rd_index  = IDX_W'(rd);  issue_rd_wen   = wen;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        rst = 1'b0;
    endtask

    task automatic run_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        rst = 1'b1;
        drain_req = 1'b0;
        idle_inputs();
        do_reset();

        // Sweep: 31 zeroing writes with ascending indices, then issue opens.
        for (int i = 1; i <= NUM_REGS; i++) begin
            step("sweep");
            if (i < NUM_REGS) begin
                check_eq("sweep_we", rf_init_we, 1);
                check_eq("sweep_idx", rf_init_index, i);
            end else begin
                check_eq("sweep_end_we", rf_init_we, 0);
                check_eq("sweep_end_ready", issue_ready, 1);
            end
        end

        // RAW on x5
        set_issue(1, 0, 0, 0, 0, 5, 1);
        step("raw_issue");
        check_eq("raw_busy", busy_vec, 32'h20);
        check_eq("raw_pend", pending_count, 1);
        set_issue(1, 5, 1, 0, 0, 0, 0);
        #1 check_eq("raw_stall", issue_ready, 0);
        step("raw_stall");
        wb_en = 1; wb_index = 5;
        #1 check_eq("raw_no_bypass", issue_ready, 0);
        step("raw_wb");
        wb_en = 0;
        check_eq("raw_cleared", busy_vec, 32'h0);
        #1 check_eq("raw_lift", issue_ready, 1);
        step("raw_fire");

        // x0 never busy; WAW on x5
        set_issue(1, 0, 0, 0, 0, 0, 1);
        step("x0_issue");
        check_eq("x0_busy", busy_vec, 32'h0);
        set_issue(1, 0, 0, 0, 0, 5, 1);
        step("waw_first");
        check_eq("waw_busy", busy_vec, 32'h20);
        #1 check_eq("waw_stall", issue_ready, 0);
        run_idle(2, "waw_wait");
        wb_en = 1; wb_index = 5;
        step("waw_wb");
        wb_en = 0;
        check_eq("waw_cleared", busy_vec, 32'h0);
        step("waw_fire");
        check_eq("waw_reissued", busy_vec, 32'h20);
        idle_inputs();
        wb_en = 1; wb_index = 5;
        step("waw_clean");
        idle_inputs();

        // Kill and wb on different indices in one cycle, then a spurious wb
        set_issue(1, 0, 0, 0, 0, 3, 1);
        step("kw_i3");
        set_issue(1, 0, 0, 0, 0, 7, 1);
        step("kw_i7");
        check_eq("kw_busy", busy_vec, 32'h88);
        idle_inputs();
        kill_en = 1; kill_index = 3; wb_en = 1; wb_index = 7;
        step("kw_clear");
        check_eq("kw_busy0", busy_vec, 32'h0);
        check_eq("kw_err0", err, 0);
        idle_inputs();
        wb_en = 1; wb_index = 9;
        step("kw_bad");
        check_eq("kw_err1", err, 1);
        idle_inputs();
        run_idle(3, "kw_sticky");
        check_eq("kw_err_sticky", err, 1);

        // Drain with x3 and x7 pending
        do_reset();
        run_idle(NUM_REGS, "sweep2");
        set_issue(1, 0, 0, 0, 0, 3, 1);
        step("dr_i3");
        set_issue(1, 0, 0, 0, 0, 7, 1);
        step("dr_i7");
        idle_inputs();
        drain_req = 1;
        step("dr_enter");
        #1 check_eq("dr_ready0", issue_ready, 0);
        wb_en = 1; wb_index = 3;
        step("dr_wb3");
        wb_index = 7;
        step("dr_wb7");
        check_eq("dr_busy0", busy_vec, 32'h0);
        check_eq("dr_done_early", drain_done, 0);
        idle_inputs();
        step("dr_wait");
        check_eq("dr_done", drain_done, 1);
        drain_req = 0;
        step("dr_exit");
        check_eq("dr_done_drop", drain_done, 0);
        set_issue(1, 0, 0, 0, 0, 2, 1);
        #1 check_eq("dr_resume", issue_ready, 1);
        step("dr_issue");
        check_eq("dr_busy2", busy_vec, 32'h4);
        idle_inputs();

        // Reset mid-sweep and mid-run
        do_reset();
        run_idle(12, "mid_sweep");
        check_eq("mid_idx12", rf_init_index, 12);
        do_reset();
        run_idle(NUM_REGS, "sweep3");
        set_issue(1, 0, 0, 0, 0, 3, 1);
        step("mr_i3");
        set_issue(1, 0, 0, 0, 0, 7, 1);
        step("mr_i7");
        check_eq("mr_busy", busy_vec, 32'h88);
        idle_inputs();
        do_reset();
        check_eq("mr_busy0", busy_vec, 32'h0);
        step("mr_restart");
        check_eq("mr_idx1", rf_init_index, 1);
        run_idle(NUM_REGS - 1, "sweep4");

        // Randomized traffic on a small register window to provoke hazards
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            issue_valid     = 1'($urandom_range(0, 1));
            issue_rs1_index = IDX_W'($urandom_range(0, 7));
            issue_rs2_index = IDX_W'($urandom_range(0, 7));
            issue_rd_index  = IDX_W'($urandom_range(0, 7));
            issue_rs1_used  = 1'($urandom_range(0, 1));
            issue_rs2_used  = 1'($urandom_range(0, 1));
            issue_rd_wen    = 1'($urandom_range(0, 1));
            wb_en           = ($urandom_range(0, 2) == 0);
            wb_index        = IDX_W'($urandom_range(0, 7));
            kill_en         = ($urandom_range(0, 9) == 0);
            kill_index      = IDX_W'($urandom_range(0, 7));
            if ($urandom_range(0, 24) == 0) drain_req = ~drain_req;
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
